// File: rtl/instruction_ram_loader.sv
// Instruction RAM loader: assembles a byte stream into 32-bit words, writes
// them to the instruction RAM and stalls the processor while a load runs.
module instruction_ram_loader #(
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_start,
  input  logic [9:0]  load_base,
  input  logic [9:0]  load_length,
  input  logic        load_abort,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] i_ram_input,
  output logic [9:0]  i_ram_writing_address,
  output logic        flag_write_i_ram,
  output logic        cpu_hold,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_aborted,
  output logic [31:0] load_checksum
);

  localparam int unsigned IDX_W = $clog2(WORD_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] byte_idx;
  logic [9:0]       addr;
  logic [9:0]       remaining;
  logic [31:0]      word;
  logic [31:0]      checksum;
  logic             aborted;

  // Load sequencer: parameter capture, byte assembly, write and completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      byte_idx  <= '0;
      addr      <= '0;
      remaining <= '0;
      word      <= '0;
      checksum  <= '0;
      aborted   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            addr      <= load_base;
            remaining <= load_length;
            checksum  <= '0;
            byte_idx  <= '0;
            aborted   <= 1'b0;
            state     <= (load_length == 10'd0) ? DONE : COLLECT;
          end
        end
        COLLECT: begin
          if (load_abort) begin
            aborted  <= 1'b1;
            byte_idx <= '0;
            state    <= IDLE;
          end else if (byte_valid) begin
            // Shifting in from the bottom leaves byte 0 in [31:24] once all
            // four bytes are in; any partial word is fully overwritten.
            word <= {word[23:0], byte_in};
            if (byte_idx == LAST_IDX) begin
              byte_idx <= '0;
              state    <= WRITE;
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
            end
          end
        end
        WRITE: begin
          checksum  <= checksum ^ word;
          addr      <= addr + 10'd1;
          remaining <= remaining - 10'd1;
          if (load_abort) begin
            aborted <= 1'b1;
            state   <= IDLE;
          end else begin
            state <= (remaining == 10'd1) ? DONE : COLLECT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decoded straight from the state register and datapath registers.
  always_comb begin
    byte_ready            = (state == COLLECT);
    flag_write_i_ram      = (state == WRITE);
    load_busy             = (state != IDLE);
    load_done             = (state == DONE);
    cpu_hold              = (state != IDLE) || load_start;
    i_ram_input           = word;
    i_ram_writing_address = addr;
    load_aborted          = aborted;
    load_checksum         = checksum;
  end

endmodule

// File: tb/tb_instruction_ram_loader.sv
// Scoreboard bench for instruction_ram_loader: directed loads push expected
// writes and checksums; a monitor pops and compares on each strobe / done.
module tb_instruction_ram_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_start;
  logic [9:0]  load_base;
  logic [9:0]  load_length;
  logic        load_abort;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] i_ram_input;
  logic [9:0]  i_ram_writing_address;
  logic        flag_write_i_ram;
  logic        cpu_hold;
  logic        load_busy;
  logic        load_done;
  logic        load_aborted;
  logic [31:0] load_checksum;

  instruction_ram_loader #(.WORD_BYTES(4)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .load_start            (load_start),
    .load_base             (load_base),
    .load_length           (load_length),
    .load_abort            (load_abort),
    .byte_in               (byte_in),
    .byte_valid            (byte_valid),
    .byte_ready            (byte_ready),
    .i_ram_input           (i_ram_input),
    .i_ram_writing_address (i_ram_writing_address),
    .flag_write_i_ram      (flag_write_i_ram),
    .cpu_hold              (cpu_hold),
    .load_busy             (load_busy),
    .load_done             (load_done),
    .load_aborted          (load_aborted),
    .load_checksum         (load_checksum)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [41:0] wr_q[$];
  logic [31:0] ck_q[$];
  logic [41:0] wr_exp;
  logic [31:0] ck_exp;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every write strobe and done pulse is checked against the queues.
  always @(negedge clock) begin
    if (flag_write_i_ram) begin
      tests++;
      if (wr_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got %h@%0d, required no write", i_ram_input, i_ram_writing_address);
      end else begin
        wr_exp = wr_q.pop_front();
        if ({i_ram_writing_address, i_ram_input} !== wr_exp) begin
          fails++;
          $display("FAIL write: got %h@%0d, required %h@%0d", i_ram_input, i_ram_writing_address, wr_exp[31:0], wr_exp[41:32]);
        end
      end
    end
    if (load_done) begin
      tests++;
      if (ck_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got load_done with checksum %h, required no done", load_checksum);
      end else begin
        ck_exp = ck_q.pop_front();
        if (load_checksum !== ck_exp) begin
          fails++;
          $display("FAIL checksum: got %h, required %h", load_checksum, ck_exp);
        end
      end
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_flag_write"}, 32'(flag_write_i_ram), 32'd0);
    chk({tag, "_i_ram_input"}, i_ram_input, 32'd0);
    chk({tag, "_address"}, 32'(i_ram_writing_address), 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_busy"}, 32'(load_busy), 32'd0);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_aborted"}, 32'(load_aborted), 32'd0);
    chk({tag, "_checksum"}, load_checksum, 32'd0);
  endtask

  task automatic start_load(input logic [9:0] base, input logic [9:0] len);
    load_base   = base;
    load_length = len;
    load_start  = 1'b1;
    start_cyc   = cyc;
    step();
    load_start  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clock);
      acc = byte_ready;
      step();
      n++;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL byte_accept_timeout: got byte_ready=0 for 50 cycles, required 1");
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic expect_write(input logic [9:0] a, input logic [31:0] d);
    wr_q.push_back({a, d});
  endtask

  // Waits for load_done at a negedge; lat < 0 skips the latency comparison.
  task automatic wait_done(input string name, input int lat);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (load_done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no load_done in 100 cycles, required load_done", name);
    end else if (lat >= 0) begin
      chk({name, "_latency"}, 32'(cyc - start_cyc), 32'(lat));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    load_start = 1'b0;
    load_base = '0;
    load_length = '0;
    load_abort = 1'b0;
    byte_in = '0;
    byte_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    @(negedge clock);
    chk_reset_state("reset");

    // Basic two-word load; done 11 cycles after the start cycle (12 inclusive).
    expect_write(10'd0, 32'h6C000000);
    expect_write(10'd1, 32'h74400000);
    ck_q.push_back(32'h18400000);
    start_load(10'd0, 10'd2);
    send_word(32'h6C000000);
    send_word(32'h74400000);
    byte_valid = 1'b0;
    wait_done("basic_done", 11);
    chk("basic_hold_at_done", 32'(cpu_hold), 32'd1);
    @(negedge clock);
    chk("basic_hold_after_done", 32'(cpu_hold), 32'd0);
    chk("basic_busy_after_done", 32'(load_busy), 32'd0);

    // Stalled stream: valid toggles, bytes accepted on cycles 1,3,5,7.
    expect_write(10'd40, 32'hDEADBEEF);
    ck_q.push_back(32'hDEADBEEF);
    start_load(10'd40, 10'd1);
    send_byte(8'hDE); byte_valid = 1'b0; step();
    send_byte(8'hAD); byte_valid = 1'b0; step();
    send_byte(8'hBE); byte_valid = 1'b0;
    @(negedge clock);
    chk("stall_ready_while_invalid", 32'(byte_ready), 32'd1);
    chk("stall_no_strobe_while_invalid", 32'(flag_write_i_ram), 32'd0);
    step();
    send_byte(8'hEF); byte_valid = 1'b0;
    wait_done("stall_done", 9);

    // Address wrap 1022 -> 1023 -> 0.
    expect_write(10'd1022, 32'h01020304);
    expect_write(10'd1023, 32'hA0B0C0D0);
    expect_write(10'd0,    32'h0F0F0F0F);
    ck_q.push_back(32'hAEBDCCDB);
    step();
    start_load(10'd1022, 10'd3);
    send_word(32'h01020304);
    send_word(32'hA0B0C0D0);
    send_word(32'h0F0F0F0F);
    byte_valid = 1'b0;
    wait_done("wrap_done", 16);

    // Abort after six bytes: one write at base, no done.
    expect_write(10'd20, 32'h11223344);
    step();
    start_load(10'd20, 10'd4);
    send_word(32'h11223344);
    send_byte(8'h55);
    send_byte(8'h66);
    byte_valid = 1'b0;
    load_abort = 1'b1;
    step();
    load_abort = 1'b0;
    @(negedge clock);
    chk("abort_flag", 32'(load_aborted), 32'd1);
    chk("abort_busy", 32'(load_busy), 32'd0);
    chk("abort_hold", 32'(cpu_hold), 32'd0);
    chk("abort_checksum_held", load_checksum, 32'h11223344);
    repeat (4) step();

    // Zero-length load: done next cycle, no strobe, checksum 0, abort cleared.
    ck_q.push_back(32'h00000000);
    start_load(10'd300, 10'd0);
    chk("zero_aborted_cleared", 32'(load_aborted), 32'd0);
    wait_done("zero_done", 1);

    // Start issued during COLLECT must not disturb the ongoing load.
    expect_write(10'd5, 32'h01234567);
    expect_write(10'd6, 32'h89ABCDEF);
    ck_q.push_back(32'h88888888);
    step();
    start_load(10'd5, 10'd2);
    load_base = 10'd100;
    load_length = 10'd7;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    send_word(32'h01234567);
    send_word(32'h89ABCDEF);
    byte_valid = 1'b0;
    wait_done("ignored_start_done", -1);
    @(negedge clock);
    chk("ignored_start_idle_after", 32'(load_busy), 32'd0);

    // Mid-load reset: outputs back to reset values, no strobe afterwards.
    step();
    start_load(10'd9, 10'd2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    byte_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    chk_reset_state("midreset");
    repeat (8) step();

    chk("writes_outstanding", 32'(wr_q.size()), 32'd0);
    chk("dones_outstanding", 32'(ck_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
